// File: rtl/bel_fft_bitrev_loader_if.sv
// Shared bus master port of the FFT datapath, as seen from the bit-reversal loader.
//   master: drives adr_o, dat_re_o, dat_im_o, wr_o, rd_o; receives ack_i, err_i
//   slave : the memory side, the mirror image of master
// Parameters: aw = bus address width, dw = width of one real/imag component.
`ifndef BEL_FFT_AWIDTH
`define BEL_FFT_AWIDTH 32
`endif

interface bel_fft_bitrev_loader_if #(
  parameter int aw = `BEL_FFT_AWIDTH,
  parameter int dw = 16
);
  logic [aw-1:0] adr_o;
  logic [dw-1:0] dat_re_o;
  logic [dw-1:0] dat_im_o;
  logic          wr_o;
  logic          rd_o;
  logic          ack_i;
  logic          err_i;

  modport master (
    output adr_o, dat_re_o, dat_im_o, wr_o, rd_o,
    input  ack_i, err_i
  );

  modport slave (
    input  adr_o, dat_re_o, dat_im_o, wr_o, rd_o,
    output ack_i, err_i
  );
endinterface

// File: rtl/bel_fft_bitrev_loader.sv
// bel_fft_bitrev_loader: FFT input stage. Accepts complex samples over a valid/ready
// stream and writes sample idx to base + rev(idx)*adr_step in working memory, so the
// in-place radix-2 stages find their operands in natural order.
// Ports:
//   clk_i, rst_n_i      clock (rising edge), asynchronous active-low reset
//   start, log2n        begin a load of N = 2**min(log2n, log2n_max) samples (IDLE only)
//   base_adr            buffer base address, latched on start
//   s_valid/s_ready     sample stream handshake, s_re/s_im signed sample
//   bus                 shared bus master port (write only, rd_o tied 0)
//   busy                high whenever the FSM is not IDLE
//   finish              one-cycle pulse in the cycle the last write is acknowledged
//   error               sticky abort flag after err_i, cleared by the next accepted start
//   o_dbg_state         current FSM state, for observation only
// Handshakes: a transfer happens on a rising edge where valid (s_valid, or wr_o toward
// the bus) and ready (s_ready, or ack_i/err_i from the bus) are both high; the side
// asserting valid holds its payload stable until that edge.
`ifndef BEL_FFT_AWIDTH
`define BEL_FFT_AWIDTH 32
`endif

module bel_fft_bitrev_loader #(
  parameter int word_width = 16,
  parameter int log2n_max  = 10,
  parameter int adr_step   = 4,
  parameter int aw         = `BEL_FFT_AWIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start,
  input  logic [3:0]            log2n,
  input  logic [aw-1:0]         base_adr,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [word_width-1:0] s_re,
  input  logic [word_width-1:0] s_im,
  bel_fft_bitrev_loader_if.master bus,
  output logic                  busy,
  output logic                  finish,
  output logic                  error,
  output logic [1:0]            o_dbg_state
);

  localparam int iw = log2n_max + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_INIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_WRITE   = 2'd3
  } state_t;

  state_t                r_state;
  logic [3:0]            r_lg;
  logic [aw-1:0]         r_base;
  logic [iw-1:0]         r_idx;
  logic [word_width-1:0] r_re;
  logic [word_width-1:0] r_im;
  logic [aw-1:0]         r_adr;
  logic                  r_error;

  logic [log2n_max-1:0]  w_rev_full;
  logic [log2n_max-1:0]  w_rev;
  logic [3:0]            w_shift;
  logic [iw-1:0]         w_nm1;
  logic                  w_last;
  logic [aw-1:0]         w_adr;
  logic                  w_wr;

  // Reverse all log2n_max bits, then shift right so only the low lg bits of idx
  // land in the result (bits of idx >= lg are always zero because idx < N).
  always_comb begin
    w_rev_full = '0;
    for (int i = 0; i < log2n_max; i++) begin
      w_rev_full[i] = r_idx[log2n_max-1-i];
    end
  end

  assign w_shift = 4'(log2n_max) - r_lg;
  assign w_rev   = w_rev_full >> w_shift;
  assign w_nm1   = (iw'(1) << r_lg) - iw'(1);
  assign w_last  = (r_idx == w_nm1);
  assign w_adr   = r_base + aw'(w_rev) * aw'(adr_step);
  assign w_wr    = (r_state == S_WRITE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_lg    <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_re    <= '0;
      r_im    <= '0;
      r_adr   <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_lg    <= (log2n > 4'(log2n_max)) ? 4'(log2n_max) : log2n;
            r_base  <= base_adr;
            r_idx   <= '0;
            r_error <= 1'b0;
            r_state <= S_INIT;
          end
        end
        S_INIT: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          if (s_valid) begin
            r_re    <= s_re;
            r_im    <= s_im;
            r_adr   <= w_adr;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // err_i wins over ack_i: the load is abandoned with no finish pulse.
          if (bus.err_i) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else if (bus.ack_i) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= r_idx + iw'(1);
              r_state <= S_CAPTURE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Bus payload is forced to zero outside WRITE so idle bus lines stay quiet.
  assign bus.wr_o     = w_wr;
  assign bus.rd_o     = 1'b0;
  assign bus.adr_o    = w_wr ? r_adr : '0;
  assign bus.dat_re_o = w_wr ? r_re  : '0;
  assign bus.dat_im_o = w_wr ? r_im  : '0;

  assign s_ready     = (r_state == S_CAPTURE);
  assign busy        = (r_state != S_IDLE);
  assign finish      = w_wr & bus.ack_i & ~bus.err_i & w_last;
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bel_fft_bitrev_loader.sv
`ifndef BEL_FFT_AWIDTH
`define BEL_FFT_AWIDTH 32
`endif

module tb_bel_fft_bitrev_loader;
  localparam int AW = `BEL_FFT_AWIDTH;
  localparam int W  = 16;
  localparam int EW = AW + 2 * W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [3:0]    log2n = '0;
  logic [AW-1:0] base_adr = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_re = '0;
  logic [W-1:0]  s_im = '0;
  logic          busy, finish, error;
  logic [1:0]    dbg_state;

  bel_fft_bitrev_loader_if #(.aw(AW), .dw(W)) bus ();

  bel_fft_bitrev_loader dut (
    .clk_i(clk), .rst_n_i(rst_n), .start(start), .log2n(log2n), .base_adr(base_adr),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .bus(bus),
    .busy(busy), .finish(finish), .error(error), .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];          // {last, adr, re, im}
  logic [AW-1:0] adr_log[$];
  int total = 0;
  int bad = 0;
  int ack_delay = 0;
  int err_on = 0;
  int wr_count = 0;
  int fin_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int rev_tb(input int k, input int lg);
    int r = 0;
    for (int i = 0; i < lg; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  always @(posedge clk) if (finish === 1'b1) fin_count++;

  // Memory responder: acks after ack_delay waiting cycles, or errors on write err_on.
  initial begin : responder
    int wait_cnt = 0;
    logic [AW-1:0] h_adr;
    logic [W-1:0]  h_re, h_im;
    logic [EW-1:0] e;
    bit            is_err;
    bus.ack_i = 1'b0;
    bus.err_i = 1'b0;
    forever begin
      @(negedge clk);
      bus.ack_i = 1'b0;
      bus.err_i = 1'b0;
      if (bus.wr_o === 1'b1) begin
        check("s_ready_in_write", 64'(s_ready), 64'd0);
        if (wait_cnt == 0) begin
          h_adr = bus.adr_o; h_re = bus.dat_re_o; h_im = bus.dat_im_o;
        end else begin
          check("hold_adr", 64'(bus.adr_o), 64'(h_adr));
          check("hold_dat", 64'({bus.dat_re_o, bus.dat_im_o}), 64'({h_re, h_im}));
        end
        if (wait_cnt >= ack_delay) begin
          wr_count++;
          adr_log.push_back(bus.adr_o);
          is_err = (err_on == wr_count);
          if (is_err) bus.err_i = 1'b1; else bus.ack_i = 1'b1;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("wr_adr", 64'(bus.adr_o), 64'(e[AW+2*W-1:2*W]));
            check("wr_dat", 64'({bus.dat_re_o, bus.dat_im_o}), 64'(e[2*W-1:0]));
            #1;
            check("finish_pulse", 64'(finish), is_err ? 64'd0 : 64'(e[EW-1]));
          end
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [3:0]    lg;
    logic [AW-1:0] base;
    int            gap;
    int            ack_dly;
    int            glitch;
    int            err_at;
    int            exp_wr;
    int            exp_fin;
    bit            exp_err;
    logic [AW-1:0] exp_last;
  } vec_t;

  task automatic load(input vec_t v);
    int  eff, n, tmo;
    bit  aborted, done;
    eff = (v.lg > 4'd10) ? 10 : int'(v.lg);
    n = 1 << eff;
    aborted = 1'b0;
    @(negedge clk);
    log2n = v.lg; base_adr = v.base; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_lat_init", 64'(s_ready), 64'd0);
    check("error_cleared", 64'(error), 64'd0);
    check("busy_init", 64'(busy), 64'd1);
    @(negedge clk);
    check("ready_lat_2", 64'(s_ready), 64'd1);
    for (int k = 0; k < n && !aborted; k++) begin
      s_valid = 1'b0;
      repeat (v.gap) @(negedge clk);
      start = (v.glitch >= 0 && (k == v.glitch || k == v.glitch + 1));
      s_re = W'(k); s_im = W'(-k); s_valid = 1'b1;
      tmo = 0; done = 1'b0;
      while (!done && !aborted) begin
        if (s_ready === 1'b1) begin
          exp_q.push_back({(k == n - 1), v.base + AW'(rev_tb(k, eff) * 4), W'(k), W'(-k)});
          @(negedge clk);
          done = 1'b1;
        end else if (error === 1'b1 && v.exp_err) begin
          aborted = 1'b1;
        end else if (tmo >= 200) begin
          check("ready_timeout", 64'd1, 64'd0);
          aborted = 1'b1;
        end else begin
          @(negedge clk);
          tmo++;
        end
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
    tmo = 0;
    while (busy === 1'b1 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    check("busy_timeout", 64'(tmo >= 100), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"}, 64'({bus.wr_o, bus.rd_o}), 64'd0);
    check({tag, "_adr_dat"}, 64'({bus.adr_o, bus.dat_re_o, bus.dat_im_o}), 64'd0);
    check({tag, "_flags"}, 64'({s_ready, busy, finish, error}), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  vec_t vecs[7];
  logic [AW-1:0] t1_adr[8];

  initial begin
    vecs[0] = '{4'd3,  32'h100,  0, 0, -1, 0, 8,    1, 1'b0, 32'h11C};
    vecs[1] = '{4'd3,  32'h100,  5, 3, -1, 0, 8,    1, 1'b0, 32'h11C};
    vecs[2] = '{4'd4,  32'h200,  0, 0, -1, 6, 6,    0, 1'b1, 32'h228};
    vecs[3] = '{4'd4,  32'h200,  0, 1, -1, 0, 16,   1, 1'b0, 32'h23C};
    vecs[4] = '{4'd3,  32'h300,  0, 0,  2, 0, 8,    1, 1'b0, 32'h31C};
    vecs[5] = '{4'd0,  32'h40,   0, 0, -1, 0, 1,    1, 1'b0, 32'h40};
    vecs[6] = '{4'd15, 32'h1000, 0, 0, -1, 0, 1024, 1, 1'b0, 32'h1FFC};
    t1_adr = '{32'h100, 32'h110, 32'h108, 32'h118, 32'h104, 32'h114, 32'h10C, 32'h11C};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      ack_delay = vecs[i].ack_dly;
      err_on = vecs[i].err_at;
      wr_count = 0; fin_count = 0;
      adr_log.delete();
      load(vecs[i]);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_writes", i), 64'(wr_count), 64'(vecs[i].exp_wr));
      check($sformatf("v%0d_finishes", i), 64'(fin_count), 64'(vecs[i].exp_fin));
      check($sformatf("v%0d_error", i), 64'(error), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_busy", i), 64'(busy), 64'd0);
      check($sformatf("v%0d_queue_empty", i), 64'(exp_q.size()), 64'd0);
      if (adr_log.size() > 0)
        check($sformatf("v%0d_last_adr", i), 64'(adr_log[adr_log.size()-1]), 64'(vecs[i].exp_last));
      else
        check($sformatf("v%0d_no_writes", i), 64'd1, 64'd0);
      if (i == 0 || i == 1) begin
        for (int j = 0; j < 8; j++)
          check($sformatf("v%0d_adr_order%0d", i, j),
                (j < adr_log.size()) ? 64'(adr_log[j]) : 64'hDEAD, 64'(t1_adr[j]));
      end
      if (i == 2) begin
        repeat (10) @(negedge clk);
        check("err_no_more_writes", 64'(wr_count), 64'd6);
        check("err_sticky", 64'(error), 64'd1);
      end
      exp_q.delete();
    end

    // Reset asserted off the clock edge while a write waits for its ack.
    ack_delay = 1000; err_on = 0; wr_count = 0; fin_count = 0;
    @(negedge clk);
    log2n = 4'd3; base_adr = 32'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    s_re = 16'h1234; s_im = 16'h5678; s_valid = 1'b1;
    exp_q.push_back({1'b0, 32'h500, 16'h1234, 16'h5678});
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pre_wr", 64'(bus.wr_o), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("midrst_no_finish", 64'(fin_count), 64'd0);
    exp_q.delete();
    ack_delay = 0; wr_count = 0; fin_count = 0;
    adr_log.delete();
    load(vecs[0]);
    repeat (3) @(negedge clk);
    check("post_rst_writes", 64'(wr_count), 64'd8);
    check("post_rst_finish", 64'(fin_count), 64'd1);
    for (int j = 0; j < 8; j++)
      check($sformatf("post_rst_adr%0d", j),
            (j < adr_log.size()) ? 64'(adr_log[j]) : 64'hDEAD, 64'(t1_adr[j]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
